// File: rtl/mul8_seq_pkg.sv
// Shared types and step tables for the sequential 8x8 multiplier.
// Each step multiplies one nibble pair and shifts the partial product into place.
package mul8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned STEP_W = 2;
    localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

    // Bit i set means step i takes the high nibble of that operand.
    localparam logic [3:0] X_HI_STEPS = 4'b1100;
    localparam logic [3:0] Y_HI_STEPS = 4'b1010;

    localparam logic [3:0] SHIFT_TABLE [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/add.sv
// N-bit ripple-style natural adder with carry in and carry out.
module add #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/mul_add_nat.sv
// Natural 4x4 multiply plus 4-bit addend; the 8-bit result cannot overflow (max 240).
module mul_add_nat (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    output logic [7:0] p
);

    assign p = ({4'h0, a} * {4'h0, b}) + {4'h0, c};

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 natural multiplier: one shared 4x4 unit, four steps per product,
// behind a start/done handshake.
module mul8_seq
    import mul8_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] m
);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [7:0]        xr;
    logic [7:0]        yr;
    logic [15:0]       acc;

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [7:0]        p;
    logic [15:0]       addend;
    logic [15:0]       sum;
    logic              sum_carry_unused;
    logic              zero_op;

    always_comb begin
        a_nib  = X_HI_STEPS[step] ? xr[7:4] : xr[3:0];
        b_nib  = Y_HI_STEPS[step] ? yr[7:4] : yr[3:0];
        addend = {8'h00, p} << SHIFT_TABLE[step];
    end

    mul_add_nat u_mul (
        .a (a_nib),
        .b (b_nib),
        .c (4'h0),
        .p (p)
    );

    // Partial sums peak at 0xFE01, so the carry out is never set.
    add #(
        .N (16)
    ) u_add (
        .a     (acc),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (sum_carry_unused)
    );

    assign zero_op = (x == 8'h00) || (y == 8'h00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            xr    <= 8'h00;
            yr    <= 8'h00;
            acc   <= 16'h0000;
            m     <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xr   <= x;
                        yr   <= y;
                        acc  <= 16'h0000;
                        step <= '0;
                        if (EARLY_EXIT && zero_op) begin
                            m     <= 16'h0000;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= sum;
                    if (step == LAST_STEP) begin
                        m     <= sum;
                        step  <= '0;
                        state <= DONE;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN) || (state == DONE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_mul8_seq.sv
// Directed-vector bench for mul8_seq; runs EARLY_EXIT=0 and EARLY_EXIT=1 side by side.
module tb_mul8_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ready0, busy0, done0;
    logic        ready1, busy1, done1;
    logic [15:0] m0, m1;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int done_cnt0 = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;
    always @(negedge clock) if (done0 === 1'b1) done_cnt0++;

    mul8_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clock (clock), .reset (reset), .start (start), .x (x), .y (y),
        .ready (ready0), .busy (busy0), .done (done0), .m (m0)
    );

    mul8_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clock (clock), .reset (reset), .start (start), .x (x), .y (y),
        .ready (ready1), .busy (busy1), .done (done1), .m (m1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the caller at the negedge just after the capture edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        start = 1'b1;
        x     = a;
        y     = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] expm, input logic [15:0] prevm,
                             input int lat_exp0, input int lat_exp1);
        int lat0 = 0;
        int lat1 = 0;
        start_op(a, b);
        for (int n = 1; n <= 8; n++) begin
            if (done0 === 1'b1 && lat0 == 0) lat0 = n;
            if (done1 === 1'b1 && lat1 == 0) lat1 = n;
            if (lat0 == 0) begin
                check({tag, " busy"}, {31'd0, busy0}, 32'd1);
                check({tag, " m hold"}, {16'd0, m0}, {16'd0, prevm});
            end
            if (lat0 != 0 && lat1 != 0) break;
            @(negedge clock);
        end
        check({tag, " latency0"}, lat0, lat_exp0);
        check({tag, " latency1"}, lat1, lat_exp1);
        check({tag, " m0"}, {16'd0, m0}, {16'd0, expm});
        check({tag, " m1"}, {16'd0, m1}, {16'd0, expm});
        @(negedge clock);
        check({tag, " ready after"}, {31'd0, ready0}, 32'd1);
        check({tag, " done drop"}, {31'd0, done0}, 32'd0);
        check({tag, " m after"}, {16'd0, m0}, {16'd0, expm});
    endtask

    initial begin
        int c_first;
        int cnt_before;
        int n;

        reset = 1'b1;
        start = 1'b0;
        x     = 8'h00;
        y     = 8'h00;
        repeat (2) @(negedge clock);
        check("reset ready", {31'd0, ready0}, 32'd1);
        check("reset busy", {31'd0, busy0}, 32'd0);
        check("reset done", {31'd0, done0}, 32'd0);
        check("reset m", {16'd0, m0}, 32'd0);
        reset = 1'b0;

        run_check("basic", 8'h12, 8'h34, 16'h03A8, 16'h0000, 5, 5);
        run_check("max", 8'hFF, 8'hFF, 16'hFE01, 16'h03A8, 5, 5);
        run_check("sweep", 8'h0F, 8'hF0, 16'h0E10, 16'hFE01, 5, 5);

        // start during RUN must be ignored
        cnt_before = done_cnt0;
        start_op(8'h05, 8'h07);
        @(negedge clock);
        start = 1'b1;
        x     = 8'hFF;
        y     = 8'hFF;
        repeat (2) @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("ignore m", {16'd0, m0}, 32'h0023);
        check("ignore one done", done_cnt0 - cnt_before, 1);
        check("ignore ready", {31'd0, ready0}, 32'd1);

        // start held high for back-to-back operations
        @(negedge clock);
        start = 1'b1;
        x     = 8'h03;
        y     = 8'h05;
        @(negedge clock);
        x = 8'h10;
        y = 8'h10;
        n = 0;
        while (done0 !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        check("held first done", {31'd0, done0}, 32'd1);
        check("held first m", {16'd0, m0}, 32'h000F);
        c_first = cycle;
        @(negedge clock);
        n = 0;
        while (done0 !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        check("held second done", {31'd0, done0}, 32'd1);
        check("held second m", {16'd0, m0}, 32'h0100);
        check("held spacing", cycle - c_first, 6);
        repeat (3) @(negedge clock);

        // reset while on step 2 aborts the operation
        start_op(8'hAB, 8'hCD);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort ready", {31'd0, ready0}, 32'd1);
        check("abort busy", {31'd0, busy0}, 32'd0);
        check("abort m", {16'd0, m0}, 32'd0);
        check("abort done", {31'd0, done0}, 32'd0);
        cnt_before = done_cnt0;
        repeat (8) @(negedge clock);
        check("abort no done", done_cnt0 - cnt_before, 0);
        run_check("after abort", 8'hAB, 8'hCD, 16'h88EF, 16'h0000, 5, 5);

        // zero operand: normal latency without early exit, one cycle with it
        run_check("zero", 8'h00, 8'h77, 16'h0000, 16'h88EF, 5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
